// File: rtl/mux_sel_serializer.sv
// mux_sel_serializer: double-buffered word-to-bit serializer driving an 8:1 mux select
module mux_sel_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] mux_din,
  output logic [2:0] mux_s,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       bit_last,
  output logic       busy
);
  localparam logic [2:0] START = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] END   = MSB_FIRST ? 3'd0 : 3'd7;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t     state_q, state_d;
  logic [7:0] din_q, din_d, pend_q, pend_d;
  logic [2:0] s_q, s_d;
  logic       pend_full_q, pend_full_d;
  logic       accept, transfer, at_end;
  assign in_ready  = ~pend_full_q;
  assign bit_valid = state_q == SHIFT;
  assign at_end    = s_q == END;
  assign bit_last  = bit_valid & at_end;
  assign busy      = bit_valid | pend_full_q;
  assign mux_din   = din_q;
  assign mux_s     = s_q;
  assign accept    = in_valid & ~pend_full_q;
  assign transfer  = bit_valid & bit_ready;
  // Next state: load on idle accept or last-bit transfer, step select otherwise, park extra words in pending
  always_comb begin
    state_d     = state_q;
    din_d       = din_q;
    s_d         = s_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (state_q == IDLE) begin
      if (accept) begin
        din_d   = in_data;
        s_d     = START;
        state_d = SHIFT;
      end
    end else if (transfer && at_end) begin
      if (pend_full_q) begin
        din_d       = pend_q;
        s_d         = START;
        pend_full_d = 1'b0;
      end else if (accept) begin
        din_d = in_data;
        s_d   = START;
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (transfer) s_d = MSB_FIRST ? s_q - 3'd1 : s_q + 3'd1;
      if (accept) begin
        pend_d      = in_data;
        pend_full_d = 1'b1;
      end
    end
  end
  // State registers; reset discards any words in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      din_q       <= 8'd0;
      s_q         <= START;
      pend_q      <= 8'd0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      din_q       <= din_d;
      s_q         <= s_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end
endmodule

// File: tb/tb_mux_sel_serializer.sv
// tb_mux_sel_serializer: directed and random checks of both bit orders against a word-queue model
module tb_mux_sel_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       bit_ready = 1'b0;
  logic       in_ready0, bit_valid0, bit_last0, busy0;
  logic       in_ready1, bit_valid1, bit_last1, busy1;
  logic [7:0] mux_din0, mux_din1;
  logic [2:0] mux_s0, mux_s1;
  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  int idx = 0;
  logic [7:0] exp_din = 8'd0;
  int exp_pos = 0;
  always #5 clk = ~clk;
  mux_sel_serializer #(.MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .mux_din(mux_din0), .mux_s(mux_s0), .bit_valid(bit_valid0), .bit_ready(bit_ready),
    .bit_last(bit_last0), .busy(busy0)
  );
  mux_sel_serializer #(.MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .mux_din(mux_din1), .mux_s(mux_s1), .bit_valid(bit_valid1), .bit_ready(bit_ready),
    .bit_last(bit_last1), .busy(busy1)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    logic v;
    logic [2:0] s0, s1;
    v  = q.size() > 0;
    s0 = 3'(exp_pos);
    s1 = 3'(7 - exp_pos);
    chk("in_ready0", {7'd0, in_ready0}, {7'd0, q.size() < 2});
    chk("in_ready1", {7'd0, in_ready1}, {7'd0, q.size() < 2});
    chk("bit_valid0", {7'd0, bit_valid0}, {7'd0, v});
    chk("bit_valid1", {7'd0, bit_valid1}, {7'd0, v});
    chk("busy0", {7'd0, busy0}, {7'd0, v});
    chk("busy1", {7'd0, busy1}, {7'd0, v});
    chk("mux_din0", mux_din0, exp_din);
    chk("mux_din1", mux_din1, exp_din);
    chk("mux_s0", {5'd0, mux_s0}, {5'd0, s0});
    chk("mux_s1", {5'd0, mux_s1}, {5'd0, s1});
    chk("bit_last0", {7'd0, bit_last0}, {7'd0, v && exp_pos == 7});
    chk("bit_last1", {7'd0, bit_last1}, {7'd0, v && exp_pos == 7});
    chk("dout0", {7'd0, mux_din0[mux_s0]}, {7'd0, exp_din[s0]});
    chk("dout1", {7'd0, mux_din1[mux_s1]}, {7'd0, exp_din[s1]});
  endtask
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    bit acc, xfer;
    @(negedge clk);
    check_all();
    in_valid  = v;
    in_data   = d;
    bit_ready = r;
    acc  = v && q.size() < 2;
    xfer = q.size() > 0 && r;
    if (xfer) begin
      if (idx == 7) begin
        void'(q.pop_front());
        idx = 0;
      end else idx++;
    end
    if (acc) q.push_back(d);
    if (q.size() > 0) begin
      exp_din = q[0];
      exp_pos = idx;
    end
  endtask
  task automatic apply_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    #1;
    q.delete();
    idx = 0;
    exp_din = 8'd0;
    exp_pos = 0;
    check_all();
    @(negedge clk);
    check_all();
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask
  initial begin
    apply_reset();
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(1, 8'h19, 1);
    repeat (10) step(0, 8'h00, 1);
    step(1, 8'hA5, 1);
    step(1, 8'h3C, 1);
    repeat (18) step(0, 8'h00, 1);
    step(1, 8'h6E, 1);
    repeat (3) step(0, 8'h00, 1);
    repeat (4) step(0, 8'h00, 0);
    repeat (7) step(0, 8'h00, 1);
    step(1, 8'hC3, 1);
    step(1, 8'h5A, 1);
    repeat (4) step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    apply_reset();
    step(1, 8'h01, 1);
    repeat (10) step(0, 8'h00, 1);
    repeat (800) step(1'($urandom), 8'($urandom), ($urandom % 4) != 0);
    repeat (600) step(($urandom % 4) == 0, 8'($urandom), 1'($urandom));
    repeat (20) step(0, 8'h00, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
